// File: rtl/ukf_pkg.sv
// Shared definitions for the UKF covariance datapath: FSM encoding, error bit
// positions, word width and a counter-width helper.
package ukf_pkg;

    localparam int FP_W    = 32;
    localparam int ERR_W   = 3;
    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_TMO = 2;

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/diag_seq_cnt.sv
// Synchronous up-counter with clear, enable and a terminal-count compare.
module diag_seq_cnt #(
    parameter int W  = 4,
    parameter int TC = 0
) (
    input  logic         clock,
    input  logic         sclr,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clock) begin
        if (sclr || clr) cnt <= '0;
        else if (en)     cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == W'(TC));

endmodule

// File: rtl/diag_seq.sv
// Streams N_ELEM operand pairs into the squared-difference unit and writes the
// returned squares, in order, into the diagonal result RAM.
module diag_seq
    import ukf_pkg::*;
#(
    parameter int N_ELEM    = 7,
    parameter int ADDR_W    = 3,
    parameter int LATENCY   = 23,
    parameter int TMO_SLACK = 4
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [FP_W-1:0]   rd_data_a,
    input  logic [FP_W-1:0]   rd_data_b,
    output logic [FP_W-1:0]   data_a_sum,
    output logic [FP_W-1:0]   data_b_sum,
    output logic              data_in_flag,
    input  logic [FP_W-1:0]   result,
    input  logic              data_available,
    input  logic              overflow,
    input  logic              underflow,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [FP_W-1:0]   wr_data
);

    localparam int TW = cnt_w(LATENCY + TMO_SLACK);

    state_t            st, st_nxt;
    logic              iss_tc, res_full, flush_tc, tmo_tc, tmo_hit;
    logic              take, wr_take;
    logic              vld_pipe;
    logic [ADDR_W-1:0] iss_cnt;
    logic [ADDR_W:0]   res_cnt;
    logic [TW-1:0]     unused_flush_cnt, unused_tmo_cnt;

    diag_seq_cnt #(.W(ADDR_W), .TC(N_ELEM - 1)) u_iss_cnt (
        .clock(clock), .sclr(sclr),
        .clr(st != ST_ISSUE), .en(st == ST_ISSUE && !iss_tc),
        .cnt(iss_cnt), .tc(iss_tc)
    );

    // Saturates at N_ELEM so surplus results are dropped.
    diag_seq_cnt #(.W(ADDR_W + 1), .TC(N_ELEM)) u_res_cnt (
        .clock(clock), .sclr(sclr),
        .clr(st == ST_IDLE), .en(wr_take),
        .cnt(res_cnt), .tc(res_full)
    );

    diag_seq_cnt #(.W(TW), .TC(LATENCY - 1)) u_flush_cnt (
        .clock(clock), .sclr(sclr),
        .clr(st != ST_FLUSH), .en(st == ST_FLUSH),
        .cnt(unused_flush_cnt), .tc(flush_tc)
    );

    // Fires on the (LATENCY+TMO_SLACK+1)-th DRAIN cycle.
    diag_seq_cnt #(.W(TW), .TC(LATENCY + TMO_SLACK)) u_tmo_cnt (
        .clock(clock), .sclr(sclr),
        .clr(st != ST_DRAIN), .en(st == ST_DRAIN),
        .cnt(unused_tmo_cnt), .tc(tmo_tc)
    );

    assign take    = (st == ST_ISSUE || st == ST_DRAIN) && data_available;
    assign wr_take = take && !res_full;

    always_comb begin
        st_nxt  = st;
        tmo_hit = 1'b0;
        case (st)
            ST_FLUSH: if (flush_tc) st_nxt = ST_IDLE;
            ST_IDLE:  if (start)    st_nxt = ST_ISSUE;
            ST_ISSUE: if (iss_tc)   st_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (res_full) begin
                    st_nxt = ST_FIN;
                end else if (tmo_tc) begin
                    st_nxt  = ST_FIN;
                    tmo_hit = 1'b1;
                end
            end
            ST_FIN:   st_nxt = ST_IDLE;
            default:  st_nxt = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            st       <= ST_FLUSH;
            vld_pipe <= 1'b0;
            err      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            st       <= st_nxt;
            vld_pipe <= rd_en;
            wr_en    <= wr_take;
            if (wr_take) begin
                wr_addr <= ADDR_W'(res_cnt);
                wr_data <= result;
            end
            if (st == ST_IDLE && start) begin
                err <= '0;
            end else begin
                if (take) begin
                    err[ERR_OVF] <= err[ERR_OVF] | overflow;
                    err[ERR_UNF] <= err[ERR_UNF] | underflow;
                end
                if (tmo_hit) err[ERR_TMO] <= 1'b1;
            end
        end
    end

    assign busy    = (st != ST_IDLE);
    assign done    = (st == ST_FIN);
    assign rd_en   = (st == ST_ISSUE);
    assign rd_addr = rd_en ? iss_cnt : '0;

    // Operand RAM is registered, so its outputs line up with the delayed strobe.
    assign data_in_flag = vld_pipe;
    assign data_a_sum   = vld_pipe ? rd_data_a : '0;
    assign data_b_sum   = vld_pipe ? rd_data_b : '0;

endmodule

// File: tb/tb_diag_seq.sv
// Bench for diag_seq: operand RAM and a 23-cycle (a-b)^2 unit are modelled
// behaviourally; writes are scored against a per-run list of required squares.
module tb_diag_seq;

    localparam int N_ELEM    = 7;
    localparam int ADDR_W    = 3;
    localparam int LATENCY   = 23;
    localparam int TMO_SLACK = 4;

    logic              clock = 1'b0;
    logic              sclr  = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, rd_en, data_in_flag, wr_en;
    logic [2:0]        err;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [31:0]       rd_data_a = '0, rd_data_b = '0;
    logic [31:0]       data_a_sum, data_b_sum, result, wr_data;
    logic              data_available, overflow, underflow;

    always #5 clock = ~clock;

    diag_seq #(.N_ELEM(N_ELEM), .ADDR_W(ADDR_W), .LATENCY(LATENCY), .TMO_SLACK(TMO_SLACK)) dut (
        .clock(clock), .sclr(sclr), .start(start), .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .data_a_sum(data_a_sum), .data_b_sum(data_b_sum), .data_in_flag(data_in_flag),
        .result(result), .data_available(data_available), .overflow(overflow),
        .underflow(underflow), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    function automatic logic [31:0] to_fp32(input real r);
        real m;
        int  e;
        if (r == 0.0) return 32'h0;
        m = r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return {1'b0, 8'(e + 127), 23'(longint'((m - 1.0) * 8388608.0))};
    endfunction

    function automatic real from_fp32(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'h0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    real         op_a [8];
    real         op_b [8];
    logic [31:0] ram_a [8];
    logic [31:0] ram_b [8];
    logic [31:0] res_ram [8];

    // Environment: registered operand RAM and squared-difference unit.
    logic [LATENCY-1:0] pv = '0;
    logic [LATENCY-1:0] po = '0;
    logic [31:0]        pr [LATENCY];
    int                 flag_ord = 0;
    logic               flag_clr = 1'b0;
    int                 drop_idx = -1;
    int                 ovf_idx  = -1;
    logic               stray    = 1'b0;

    always @(posedge clock) begin
        if (rd_en) begin
            rd_data_a <= ram_a[rd_addr];
            rd_data_b <= ram_b[rd_addr];
        end
        pv <= {pv[LATENCY-2:0], data_in_flag && ((flag_ord % N_ELEM) != drop_idx)};
        po <= {po[LATENCY-2:0], (flag_ord % N_ELEM) == ovf_idx};
        for (int k = LATENCY - 1; k > 0; k--) pr[k] <= pr[k-1];
        pr[0] <= to_fp32((from_fp32(data_a_sum) - from_fp32(data_b_sum)) *
                         (from_fp32(data_a_sum) - from_fp32(data_b_sum)));
        if (flag_clr)          flag_ord <= 0;
        else if (data_in_flag) flag_ord <= flag_ord + 1;
    end

    assign data_available = pv[LATENCY-1] | stray;
    assign overflow       = pv[LATENCY-1] & po[LATENCY-1];
    assign underflow      = stray;
    assign result         = stray ? 32'h40000000 : pr[LATENCY-1];

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_run(input int drop);
        wr_t e;
        int  k;
        k = 0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (i != drop) begin
                e.addr = k;
                e.data = to_fp32((op_a[i] - op_b[i]) * (op_a[i] - op_b[i]));
                exp_q.push_back(e);
                k++;
            end
        end
    endtask

    // Advance to mid-cycle and score every write and every issued operand pair.
    task automatic tick();
        wr_t e;
        @(negedge clock);
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_unexpected: addr %0d data 0x%0h, no write required", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", wr_data, e.data);
            end
            res_ram[wr_addr] = wr_data;
        end
        if (data_in_flag) begin
            chk("op_a", data_a_sum, ram_a[flag_ord % N_ELEM]);
            chk("op_b", data_b_sum, ram_b[flag_ord % N_ELEM]);
        end
    endtask

    // One run from IDLE; cycle 0 is the cycle in which start is sampled.
    task automatic run(input string tag, input int req_done, input logic [2:0] req_err);
        int n, first_flag, n_flags;
        logic seen;
        tick();
        chk({tag, "_idle_before"}, 32'(busy), 32'd0);
        start      = 1'b1;
        flag_clr   = 1'b1;
        n          = 0;
        first_flag = -1;
        n_flags    = 0;
        seen       = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            if (n == 1) begin start = 1'b0; flag_clr = 1'b0; end
            if (data_in_flag) begin
                if (first_flag < 0) first_flag = n;
                n_flags++;
            end
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_cycle"}, 32'(n), 32'(req_done));
        chk({tag, "_first_flag"}, 32'(first_flag), 32'd2);
        chk({tag, "_flag_count"}, 32'(n_flags), 32'(N_ELEM));
        chk({tag, "_err"}, 32'(err), 32'(req_err));
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int m, d1, d2;
        for (int i = 0; i < 8; i++) begin
            op_a[i]    = real'(i) + 1.0;
            op_b[i]    = 0.5;
            ram_a[i]   = to_fp32(op_a[i]);
            ram_b[i]   = to_fp32(op_b[i]);
            res_ram[i] = 32'hDEADBEEF;
        end

        // Reset: outputs cleared, then LATENCY cycles of FLUSH.
        tick(); tick(); tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_outs_zero", 32'(|{done, err, rd_en, rd_addr, data_in_flag, data_a_sum,
                                   data_b_sum, wr_en, wr_addr, wr_data}), 32'd0);
        sclr = 1'b0;
        m = 0;
        while (busy && m < 40) begin m++; tick(); end
        chk("rst_flush_len", 32'(m), 32'(LATENCY));

        expect_run(-1);
        run("nom", 33, 3'b000);
        chk("nom_addr0", res_ram[0], 32'h3E800000);
        chk("nom_addr1", res_ram[1], 32'h40100000);
        chk("nom_addr6", res_ram[6], 32'h42290000);

        // Fifth result lost: timeout 28 cycles after the last flag (cycle 8).
        res_ram[6] = 32'hDEADBEEF;
        drop_idx = 4;
        expect_run(4);
        run("miss", 36, 3'b100);
        drop_idx = -1;
        chk("miss_addr4", res_ram[4], 32'h41F20000);
        chk("miss_addr5", res_ram[5], 32'h42290000);
        chk("miss_addr6", res_ram[6], 32'hDEADBEEF);

        ovf_idx = 2;
        expect_run(-1);
        run("ovf", 33, 3'b001);
        ovf_idx = -1;

        // Stray result in IDLE carrying underflow: no write, err untouched.
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("stray_wr_en", 32'(wr_en), 32'd0);
        chk("stray_err", 32'(err), 32'b001);

        expect_run(-1);
        run("clean", 33, 3'b000);

        // sclr at cycle 10 of a run; in-flight results land during FLUSH.
        tick();
        start = 1'b1;
        flag_clr = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) begin start = 1'b0; flag_clr = 1'b0; end
        end
        sclr = 1'b1;
        flag_clr = 1'b1;
        tick();
        sclr = 1'b0;
        flag_clr = 1'b0;
        for (int k = 1; k <= LATENCY; k++) begin
            chk("flush_busy", 32'(busy), 32'd1);
            chk("flush_outs_zero", 32'(|{done, err, rd_en, rd_addr, data_in_flag, data_a_sum,
                                         data_b_sum, wr_en, wr_addr, wr_data}), 32'd0);
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            tick();
        end
        chk("flush_exit_idle", 32'(busy), 32'd0);

        expect_run(-1);
        run("post_rst", 33, 3'b000);

        // start held: back-to-back runs, one IDLE cycle between done and rd_en.
        expect_run(-1);
        expect_run(-1);
        tick();
        start = 1'b1;
        flag_clr = 1'b1;
        m  = 0;
        d1 = -1;
        d2 = -1;
        while (d2 < 0 && m < 100) begin
            tick();
            m++;
            if (m == 1) flag_clr = 1'b0;
            if (m == 34) chk("held_gap_rd_en", 32'(rd_en), 32'd0);
            if (m == 35) begin
                chk("held_next_rd_en", 32'(rd_en), 32'd1);
                chk("held_next_rd_addr", 32'(rd_addr), 32'd0);
            end
            if (done) begin
                if (d1 < 0) d1 = m;
                else        d2 = m;
            end
        end
        start = 1'b0;
        chk("held_done1", 32'(d1), 32'd33);
        chk("held_done2", 32'(d2), 32'd67);
        chk("held_writes_left", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        chk("held_stop_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/diag_seq.md
Name: diag_seq

Overview:
- Sequencer and collector wrapped around the squared-difference unit (fpsub -> fpsquare, fixed pipeline latency, valid-in/valid-out flags).
- On start, reads N_ELEM operand pairs from a dual-output operand RAM and streams one pair per cycle into the unit.
- Captures each returned square and writes it, in order, into the diagonal result RAM.
- Flags arithmetic errors and a missing-result timeout, then pulses done. Sits between the UKF sigma/mean storage and the diagonal covariance store.

Parameters:
- N_ELEM, 7, number of diagonal elements per run (UKF state dimension); 1..2**ADDR_W.
- ADDR_W, 3, operand and result RAM address width.
- LATENCY, 23, cycles from data_in_flag to data_available in the squared-difference unit.
- TMO_SLACK, 4, extra drain cycles tolerated beyond LATENCY before timeout.

Ports:
- clock  in  1  system clock.
- sclr  in  1  synchronous active-high reset.
- start  in  1  run request, sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of run.
- err  out  3  sticky per run: [0] overflow seen, [1] underflow seen, [2] timeout.
- rd_en  out  1  operand RAM read strobe.
- rd_addr  out  ADDR_W  operand RAM address.
- rd_data_a  in  32  operand a; valid the cycle after rd_en (registered RAM).
- rd_data_b  in  32  operand b; same timing as rd_data_a.
- data_a_sum  out  32  minuend to the squared-difference unit.
- data_b_sum  out  32  subtrahend to the squared-difference unit.
- data_in_flag  out  1  operands valid this cycle.
- result  in  32  square from the unit; aligned with data_available.
- data_available  in  1  result valid.
- overflow  in  1  unit overflow, qualified by data_available.
- underflow  in  1  unit underflow, qualified by data_available.
- wr_en  out  1  result RAM write strobe.
- wr_addr  out  ADDR_W  result RAM address.
- wr_data  out  32  result RAM data.

Behaviour:
- sclr value of every output: 0. The state after sclr is FLUSH, not IDLE.
- States: FLUSH, IDLE, ISSUE, DRAIN, FIN.
- FLUSH:
  - Counts LATENCY cycles, then goes to IDLE.
  - data_available is ignored (empties the unit's pipeline after a reset mid-run).
  - busy=1; start is ignored.
- IDLE:
  - start=1 clears err, the issue counter and the result counter, then goes to ISSUE.
  - Stray data_available is ignored: no write, no err update.
- ISSUE:
  - Cycle k (k=0..N_ELEM-1): rd_en=1, rd_addr=k.
  - Cycle k+1: data_in_flag=1, data_a_sum/data_b_sum = rd_data_a/rd_data_b, registered.
  - Exactly N_ELEM flag cycles, back-to-back.
  - After the last rd_en, go to DRAIN.
- Collection (ISSUE or DRAIN):
  - data_available=1 at cycle t gives wr_en=1 at t+1, with wr_addr = result count and wr_data = result sampled at t.
  - The result counter then increments.
  - err[0] |= overflow and err[1] |= underflow, both only when data_available=1.
- DRAIN:
  - Timeout counter resets on entry.
  - When the result count reaches N_ELEM, go to FIN.
  - If the counter reaches LATENCY+TMO_SLACK+1 first, set err[2] and go to FIN; missing entries are not written.
- FIN: done=1 for one cycle, then IDLE.
- Results beyond N_ELEM in a run are dropped; the counter saturates and no write occurs.
- Latency: start sampled at cycle 0. Flags occur at cycles 2..N_ELEM+1. With the nominal unit, the last write is at cycle N_ELEM+LATENCY+2 and done at N_ELEM+LATENCY+3 (33 for defaults).
- sclr in any state overrides everything and re-enters FLUSH.
- The unit's clk_en must be held high by the integrator; this block never stalls.

Decomposition:
- Shared package ukf_pkg: FSM state encoding localparams (ST_FLUSH, ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FIN), the err bit index constants, and the FP32 width constant.
- Counters and FSM stay in diag_seq.
- One natural sub-module: diag_seq_cnt, a generic synchronous up-counter with clear, enable and terminal-count compare. It is instanced for the issue, result, flush and timeout counters.

Test Plan:
- Nominal run, defaults, unit modelled as a 23-cycle delay of (a-b)^2:
  - Stimulus: a[i]=i+1.0, b[i]=0.5.
  - Required: writes addr0=0x3E800000, addr1=0x40100000, addr6=0x42290000.
  - done at cycle 33, err=000.
- Missing result: the model drops the 5th result -> 6 writes, err[2]=1, done 28 cycles after the last flag.
- Error flags: overflow=1 on the 3rd result only -> err=001 at done; next run with clean data -> err=000.
- Reset mid-run: sclr at cycle 10 of a run.
  - Required: all outputs 0, busy=1 for 23 cycles, no wr_en from in-flight results.
  - start during FLUSH ignored; a new run after FLUSH completes correctly.
- start held high continuously:
  - Required: runs back-to-back with one IDLE cycle between done and the next rd_en.
  - start asserted during ISSUE/DRAIN does not restart the run.
- Stray data_available pulse in IDLE -> no wr_en, err unchanged.
